// File: rtl/sram_weight_rmw_ctrl.sv
// sram_weight_rmw_ctrl: read / saturating read-modify-write controller for the synaptic weight SRAM bank
// Ports: CK, RST_N (async active-low); req_* request channel (op 0=read, 1=update, per-lane signed deltas);
// rsp_* response channel (data, saturation flag, address error); busy; SRAM_CS/WE/A/D drive the bank, SRAM_Q is its read data.
module sram_weight_rmw_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int W_WIDTH     = 8,
    parameter int TOTAL_DEPTH = 12544,
    localparam int AW         = $clog2(TOTAL_DEPTH)
) (
    input  logic                  CK,
    input  logic                  RST_N,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_op,
    input  logic [AW-1:0]         req_addr,
    input  logic [DATA_WIDTH-1:0] req_delta,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_sat,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  SRAM_CS,
    output logic                  SRAM_WE,
    output logic [AW-1:0]         SRAM_A,
    output logic [DATA_WIDTH-1:0] SRAM_D,
    input  logic [DATA_WIDTH-1:0] SRAM_Q
);
    localparam int LANES = DATA_WIDTH / W_WIDTH;
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RSP} state_t;
    state_t state, state_n;
    logic                  op_q;
    logic [AW-1:0]         addr_q;
    logic [DATA_WIDTH-1:0] delta_q, result_q, sat_word;
    logic [LANES-1:0]      lane_ov;
    logic                  accept, addr_bad;
    assign accept   = req_valid && req_ready;
    assign addr_bad = 32'(req_addr) >= 32'(TOTAL_DEPTH);
    // Each lane sums in W_WIDTH+1 bits; the top two sum bits differing means overflow, and the extra sign bit picks the clamp rail.
    genvar i;
    generate
        for (i = 0; i < LANES; i++) begin : g_lane
            logic [W_WIDTH-1:0] q, d;
            logic [W_WIDTH:0]   sum;
            assign q          = SRAM_Q[i*W_WIDTH +: W_WIDTH];
            assign d          = delta_q[i*W_WIDTH +: W_WIDTH];
            assign sum        = {q[W_WIDTH-1], q} + {d[W_WIDTH-1], d};
            assign lane_ov[i] = sum[W_WIDTH] != sum[W_WIDTH-1];
            assign sat_word[i*W_WIDTH +: W_WIDTH] = lane_ov[i] ? {sum[W_WIDTH], {(W_WIDTH-1){~sum[W_WIDTH]}}} : sum[W_WIDTH-1:0];
        end
    endgenerate
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? (addr_bad ? RSP : RD) : IDLE;
            RD:      state_n = CAP;
            CAP:     state_n = op_q ? WR : RSP;
            WR:      state_n = RSP;
            RSP:     state_n = rsp_ready ? IDLE : RSP;
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        SRAM_CS   = state == RD || state == WR;
        SRAM_WE   = state == WR;
        SRAM_A    = SRAM_CS ? addr_q : '0;
        SRAM_D    = SRAM_WE ? result_q : '0;
        req_ready = RST_N && state == IDLE;
        rsp_valid = state == RSP;
        busy      = state != IDLE;
    end
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            op_q     <= 1'b0;
            addr_q   <= '0;
            delta_q  <= '0;
            result_q <= '0;
            rsp_data <= '0;
            rsp_sat  <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            if (accept) begin
                op_q     <= req_op;
                addr_q   <= req_addr;
                delta_q  <= req_delta;
                rsp_data <= '0;
                rsp_sat  <= 1'b0;
                rsp_err  <= addr_bad;
            end
            if (state == CAP && op_q) begin
                result_q <= sat_word;
                rsp_sat  <= |lane_ov;
            end
            if (state == CAP && !op_q) rsp_data <= SRAM_Q;
            if (state == WR) rsp_data <= result_q;
        end
    end
endmodule
